// File: rtl/draw_square_grid.sv
// Highlights one cell of a GRID_N x GRID_N board over a video stream.
// Two-stage pipeline; selection changes take effect on the next vsync rising edge.
module draw_square_grid #(
    parameter int unsigned GRID_N    = 3,
    parameter int unsigned X0        = 8,
    parameter int unsigned Y0        = 10,
    parameter int unsigned CELL_W    = 336,
    parameter int unsigned CELL_H    = 249,
    parameter int unsigned OUTLINE_W = 4,
    parameter int unsigned BLINK_DIV = 30,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic              en,
    input  logic              sel_valid,
    input  logic [IDX_W-1:0]  sel_idx,
    input  logic [1:0]        sel_mode,
    input  logic [11:0]       square_color,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out,
    output logic              frame_tick
);

    localparam int unsigned CELLS = GRID_N * GRID_N;
    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_OUTLINE = 2'd3;

    logic [IDX_W-1:0] pend_idx, act_idx;
    logic [1:0]       pend_mode, act_mode;
    logic [CNT_W-1:0] frame_cnt;
    logic             blink_phase;

    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q, color_q;
    logic        in_cell_q, on_edge_q, fill_q, outline_q, tick_q;

    logic        sel_ok_c, vs_rise_c, in_cell_c, on_edge_c, fill_c;
    int unsigned row_c, col_c, x_lo_c, x_hi_c, y_lo_c, y_hi_c, h_c, v_c;

    // Active cell bounds at 32-bit width so bounds past 2047 can never match an 11-bit counter
    always_comb begin
        sel_ok_c  = sel_valid && (32'(sel_idx) < CELLS);
        vs_rise_c = vsync_in && !vsync_q;
        row_c     = 32'(act_idx) / GRID_N;
        col_c     = 32'(act_idx) % GRID_N;
        x_lo_c    = X0 + col_c * CELL_W;
        x_hi_c    = x_lo_c + CELL_W - 1;
        y_lo_c    = Y0 + row_c * CELL_H;
        y_hi_c    = y_lo_c + CELL_H - 1;
        h_c       = 32'(hcount_in);
        v_c       = 32'(vcount_in);
        in_cell_c = (h_c >= x_lo_c) && (h_c <= x_hi_c) &&
                    (v_c >= y_lo_c) && (v_c <= y_hi_c);
        on_edge_c = in_cell_c &&
                    ((h_c < x_lo_c + OUTLINE_W) || (h_c + OUTLINE_W > x_hi_c) ||
                     (v_c < y_lo_c + OUTLINE_W) || (v_c + OUTLINE_W > y_hi_c));
        fill_c    = (act_mode == MODE_SOLID) || ((act_mode == MODE_BLINK) && blink_phase);
    end

    // Pending/active selection; a strobe coinciding with a frame edge bypasses pending
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_idx  <= '0;
            pend_mode <= MODE_OFF;
            act_idx   <= '0;
            act_mode  <= MODE_OFF;
        end else begin
            if (sel_ok_c) begin
                pend_idx  <= sel_idx;
                pend_mode <= sel_mode;
            end
            if (vs_rise_c) begin
                act_idx  <= sel_ok_c ? sel_idx  : pend_idx;
                act_mode <= sel_ok_c ? sel_mode : pend_mode;
            end
        end
    end

    // Blink timing; disabled overlay restarts in the visible phase
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!en) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (vs_rise_c) begin
            if (frame_cnt == CNT_W'(BLINK_DIV - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: timing, pixel and per-pixel qualifiers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q  <= '0;
            vcount_q  <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            hblnk_q   <= 1'b0;
            vblnk_q   <= 1'b0;
            rgb_q     <= '0;
            color_q   <= '0;
            in_cell_q <= 1'b0;
            on_edge_q <= 1'b0;
            fill_q    <= 1'b0;
            outline_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            hcount_q  <= hcount_in;
            vcount_q  <= vcount_in;
            hsync_q   <= hsync_in;
            vsync_q   <= vsync_in;
            hblnk_q   <= hblnk_in;
            vblnk_q   <= vblnk_in;
            rgb_q     <= rgb_in;
            color_q   <= square_color;
            in_cell_q <= en && !hblnk_in && !vblnk_in && in_cell_c;
            on_edge_q <= on_edge_c;
            fill_q    <= fill_c;
            outline_q <= (act_mode == MODE_OUTLINE);
            tick_q    <= vs_rise_c;
        end
    end

    // Stage 2: composite and output registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            hcount_out <= hcount_q;
            vcount_out <= vcount_q;
            hsync_out  <= hsync_q;
            vsync_out  <= vsync_q;
            hblnk_out  <= hblnk_q;
            vblnk_out  <= vblnk_q;
            rgb_out    <= (in_cell_q && (fill_q || (outline_q && on_edge_q))) ? color_q : rgb_q;
            frame_tick <= tick_q;
        end
    end

endmodule

// File: tb/tb_draw_square_grid.sv
// Scoreboard bench for draw_square_grid: stimulus queues expected pixels, a monitor checks them.
module tb_draw_square_grid;

    localparam logic [11:0] COLOR = 12'hF00;

    logic        pclk, rst_n;
    logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_in, rgb_out, square_color;
    logic        en, sel_valid, frame_tick;
    logic [3:0]  sel_idx;
    logic [1:0]  sel_mode;

    typedef struct {
        int unsigned due;
        logic [11:0] rgb;
        logic [10:0] h;
        logic [10:0] v;
        logic        vs;
        logic [1:0]  bl;
        logic        tick;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned cyc;
    int          checks, errors;
    logic        prev_vs;

    draw_square_grid #(.BLINK_DIV(2)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .en(en), .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_mode(sel_mode),
        .square_color(square_color),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .frame_tick(frame_tick)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor: pops every expectation whose output cycle has arrived
    always @(negedge pclk) begin
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                mon_e = sb_q.pop_front();
                checks++;
                if (mon_e.due != cyc) begin
                    errors++;
                    $display("FAIL latency: item due %0d seen at cycle %0d", mon_e.due, cyc);
                end
                checks++;
                if (rgb_out !== mon_e.rgb) begin
                    errors++;
                    $display("FAIL rgb at (%0d,%0d): got %h expected %h", mon_e.h, mon_e.v, rgb_out, mon_e.rgb);
                end
                checks++;
                if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
                    {mon_e.h, mon_e.v, mon_e.bl[0], mon_e.vs, mon_e.bl[0], mon_e.bl[1]}) begin
                    errors++;
                    $display("FAIL timing: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b expected h=%0d v=%0d vs=%b bl=%b",
                             hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                             mon_e.h, mon_e.v, mon_e.vs, mon_e.bl);
                end
                checks++;
                if (frame_tick !== mon_e.tick) begin
                    errors++;
                    $display("FAIL frame_tick at cycle %0d: got %b expected %b", cyc, frame_tick, mon_e.tick);
                end
            end
        end
    end

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic vs,
                         input logic [1:0] bl, input logic hit);
        exp_t        e;
        logic [11:0] rgb;
        rgb       = {h[3:0], v[3:0], 4'h5};
        hcount_in = h;
        vcount_in = v;
        vsync_in  = vs;
        hsync_in  = bl[0];
        hblnk_in  = bl[0];
        vblnk_in  = bl[1];
        rgb_in    = rgb;
        e.due     = cyc + 2;
        e.rgb     = hit ? COLOR : rgb;
        e.h       = h;
        e.v       = v;
        e.vs      = vs;
        e.bl      = bl;
        e.tick    = vs && !prev_vs;
        prev_vs   = vs;
        sb_q.push_back(e);
        @(posedge pclk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic hit);
        drive(11'(h), 11'(v), 1'b0, 2'b00, hit);
    endtask

    task automatic vframe();
        drive(11'd0, 11'd0, 1'b1, 2'b11, 1'b0);
        drive(11'd0, 11'd0, 1'b1, 2'b11, 1'b0);
        drive(11'd0, 11'd0, 1'b0, 2'b11, 1'b0);
    endtask

    task automatic select(input int idx, input int mode);
        sel_idx   = 4'(idx);
        sel_mode  = 2'(mode);
        sel_valid = 1'b1;
        drive(11'd0, 11'd0, 1'b0, 2'b11, 1'b0);
        sel_valid = 1'b0;
    endtask

    task automatic vframe_sel(input int idx, input int mode);
        sel_idx   = 4'(idx);
        sel_mode  = 2'(mode);
        sel_valid = 1'b1;
        drive(11'd0, 11'd0, 1'b1, 2'b11, 1'b0);
        sel_valid = 1'b0;
        drive(11'd0, 11'd0, 1'b1, 2'b11, 1'b0);
        drive(11'd0, 11'd0, 1'b0, 2'b11, 1'b0);
    endtask

    task automatic check_zero(input string name);
        logic [38:0] outs;
        outs = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, frame_tick};
        checks++;
        if (outs !== 39'd0) begin
            errors++;
            $display("FAIL %s: outputs %h expected 0", name, outs);
        end
    endtask

    initial begin
        logic blink_exp [5];
        blink_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        checks = 0; errors = 0; prev_vs = 1'b0;
        rst_n = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        rgb_in = '0; en = 0; sel_valid = 0; sel_idx = '0; sel_mode = '0; square_color = COLOR;
        #3;
        check_zero("reset_initial");
        repeat (2) @(posedge pclk);
        #1 rst_n = 1'b1;

        // Pass-through after reset, selection waits for a frame edge
        pix(500, 300, 0);
        select(4, 1);
        pix(600, 400, 0);
        en = 1'b1;
        pix(600, 400, 0);
        vframe();

        // Solid cell 4: x 344..679, y 259..507
        pix(344, 259, 1); pix(679, 507, 1); pix(600, 400, 1);
        pix(343, 300, 0); pix(680, 300, 0); pix(500, 258, 0); pix(500, 508, 0);
        drive(11'd600, 11'd400, 1'b0, 2'b01, 1'b0);
        drive(11'd600, 11'd400, 1'b0, 2'b10, 1'b0);
        en = 1'b0; pix(600, 400, 0);
        en = 1'b1; pix(600, 400, 1);

        // Mid-frame update and out-of-range index
        select(2, 1);
        pix(800, 100, 0); pix(600, 400, 1);
        select(9, 3);
        pix(600, 400, 1);
        vframe();
        pix(800, 100, 1); pix(600, 400, 0); pix(100, 100, 0);
        vframe_sel(4, 1);
        pix(600, 400, 1); pix(800, 100, 0);

        // Outline cell 8: x 680..1015, y 508..756
        select(8, 3);
        vframe();
        pix(680, 600, 1); pix(683, 600, 1); pix(684, 600, 0);
        pix(1012, 600, 1); pix(1015, 600, 1); pix(1011, 600, 0); pix(1016, 600, 0);
        pix(850, 508, 1); pix(850, 511, 1); pix(850, 512, 0);
        pix(850, 753, 1); pix(850, 756, 1); pix(850, 752, 0); pix(850, 757, 0);
        pix(850, 600, 0);

        // Blink on cell 0 with two frames per half-period
        select(0, 2);
        en = 1'b0; pix(100, 100, 0);
        en = 1'b1;
        vframe();
        pix(100, 100, 1);
        for (int i = 0; i < 5; i++) begin
            vframe();
            pix(100, 100, blink_exp[i]);
        end
        en = 1'b0; pix(100, 100, 0);
        en = 1'b1; pix(100, 100, 1);
        vframe(); pix(100, 100, 1);
        vframe(); pix(100, 100, 0);

        // Asynchronous reset in mid-frame
        pix(100, 100, 0);
        repeat (3) @(posedge pclk);
        #3 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge pclk);
        #1 rst_n = 1'b1;
        prev_vs = 1'b0;
        pix(100, 100, 0); pix(600, 400, 0); pix(850, 508, 0);

        repeat (4) @(posedge pclk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
